spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl.sv | 172 +++++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_ctrl.sv
// SPI register controller: command byte plus data bytes access a small register file.
// Define SPI_REG_CTRL_BLINK_EN to build the PMOD blink counter and the BLINK_DIV register.
module spi_reg_ctrl #(
    parameter logic [7:0] ID_VALUE = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ssel_active,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [7:0] tx_byte,
    output logic       tx_load,
    output logic [3:0] leds,
    output logic       pmod,
    output logic       cmd_err
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StCmd  = 3'd1;
    localparam logic [2:0] StWr   = 3'd2;
    localparam logic [2:0] StRd   = 3'd3;
    localparam logic [2:0] StErr  = 3'd4;

    logic [2:0] state_q;
    logic [3:0] addr_q;
    logic [3:0] led_q;
    logic       pmod_lvl_q;
    logic [7:0] scratch_q;
    logic [7:0] frame_cnt_q;
    logic [7:0] tx_byte_q;
    logic       tx_load_q;
    logic       cmd_err_q;

    logic       cmd_ok;
    logic [3:0] rd_addr;
    logic       reached;
    logic       wr_en;
    logic       blink_rd;
    logic [7:0] div_rd;

    assign cmd_ok  = (rx_byte[6:4] == 3'b000);
    // Address whose contents the next tx_load will carry.
    assign rd_addr = (state_q == StCmd) ? rx_byte[3:0] : addr_q + 4'd1;
    assign reached = (state_q == StWr) || (state_q == StRd) ||
                     ((state_q == StCmd) && rx_valid && cmd_ok);
    assign wr_en   = (state_q == StWr) && rx_valid;

    function automatic logic [7:0] reg_read(input logic [3:0] a);
        logic [7:0] rdata;
        rdata = 8'h00;
        case (a)
            4'h0:    rdata = {4'b0000, led_q};
            4'h1:    rdata = {6'b000000, blink_rd, pmod_lvl_q};
            4'h2:    rdata = div_rd;
            4'h3:    rdata = scratch_q;
            4'h4:    rdata = frame_cnt_q;
            4'hF:    rdata = ID_VALUE;
            default: rdata = 8'h00;
        endcase
        return rdata;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            addr_q      <= 4'h0;
            tx_byte_q   <= 8'h00;
            tx_load_q   <= 1'b0;
            cmd_err_q   <= 1'b0;
            frame_cnt_q <= 8'h00;
        end else begin
            tx_load_q <= 1'b0;
            case (state_q)
                StIdle: if (ssel_active) state_q <= StCmd;
                StCmd: begin
                    if (rx_valid) begin
                        addr_q <= rx_byte[3:0];
                        if (!cmd_ok) begin
                            state_q   <= StErr;
                            cmd_err_q <= 1'b1;
                        end else if (rx_byte[7]) begin
                            state_q <= StWr;
                        end else begin
                            state_q <= StRd;
                            if (ssel_active) begin
                                tx_byte_q <= reg_read(rd_addr);
                                tx_load_q <= 1'b1;
                            end
                        end
                    end
                end
                StWr: if (rx_valid) addr_q <= addr_q + 4'd1;
                StRd: begin
                    if (rx_valid) begin
                        addr_q <= addr_q + 4'd1;
                        if (ssel_active) begin
                            tx_byte_q <= reg_read(rd_addr);
                            tx_load_q <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
            // Frame end overrides any transition taken above; the byte itself still lands.
            if (!ssel_active) begin
                state_q <= StIdle;
                if (reached) frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q      <= 4'h0;
            pmod_lvl_q <= 1'b0;
            scratch_q  <= 8'h00;
        end else if (wr_en) begin
            case (addr_q)
                4'h0:    led_q      <= rx_byte[3:0];
                4'h1:    pmod_lvl_q <= rx_byte[0];
                4'h3:    scratch_q  <= rx_byte;
                default: ;
            endcase
        end
    end

`ifdef SPI_REG_CTRL_BLINK_EN
    logic        pmod_blink_q;
    logic [7:0]  blink_div_q;
    logic [23:0] blink_cnt_q;
    logic        pmod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pmod_blink_q <= 1'b0;
            blink_div_q  <= 8'h00;
        end else if (wr_en) begin
            if (addr_q == 4'h1) pmod_blink_q <= rx_byte[1];
            if (addr_q == 4'h2) blink_div_q  <= rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= 24'h000000;
            pmod_q      <= 1'b0;
        end else if (!pmod_blink_q) begin
            blink_cnt_q <= 24'h000000;
            pmod_q      <= pmod_lvl_q;
        end else if (blink_cnt_q == {blink_div_q, 16'hFFFF}) begin
            blink_cnt_q <= 24'h000000;
            pmod_q      <= ~pmod_q;
        end else begin
            blink_cnt_q <= blink_cnt_q + 24'd1;
        end
    end

    assign blink_rd = pmod_blink_q;
    assign div_rd   = blink_div_q;
    assign pmod     = pmod_q;
`else
    assign blink_rd = 1'b0;
    assign div_rd   = 8'h00;
    assign pmod     = pmod_lvl_q;
`endif

    assign tx_byte = tx_byte_q;
    assign tx_load = tx_load_q;
    assign cmd_err = cmd_err_q;
    assign leds    = led_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Randomised scoreboard bench for spi_reg_ctrl against a frame-level register model.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ssel_active;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [3:0] leds;
    logic       pmod;
    logic       cmd_err;

    spi_reg_ctrl #(.ID_VALUE(8'hA5)) dut (
        .clk(clk), .rst(rst), .ssel_active(ssel_active), .rx_valid(rx_valid),
        .rx_byte(rx_byte), .tx_byte(tx_byte), .tx_load(tx_load), .leds(leds),
        .pmod(pmod), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Register-file model
    logic [3:0] m_led;
    logic       m_lvl;
    logic       m_blink;
    logic [7:0] m_div;
    logic [7:0] m_scratch;
    logic [7:0] m_fcnt;
    logic       m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] m_read(input logic [3:0] a);
        case (a)
            4'h0:    return {4'h0, m_led};
            4'h1:    return {6'h00, m_blink, m_lvl};
            4'h2:    return m_div;
            4'h3:    return m_scratch;
            4'h4:    return m_fcnt;
            4'hF:    return 8'hA5;
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_write(input logic [3:0] a, input logic [7:0] v);
        case (a)
            4'h0: m_led = v[3:0];
            4'h1: begin
                m_lvl = v[0];
`ifdef SPI_REG_CTRL_BLINK_EN
                m_blink = v[1];
`endif
            end
`ifdef SPI_REG_CTRL_BLINK_EN
            4'h2: m_div = v;
`endif
            4'h3: m_scratch = v;
            default: ;
        endcase
    endtask

    task automatic m_reset();
        m_led = 4'h0; m_lvl = 1'b0; m_blink = 1'b0; m_div = 8'h00;
        m_scratch = 8'h00; m_fcnt = 8'h00; m_err = 1'b0;
        exp_q.delete();
    endtask

    // Monitor: every tx_load consumes one expected byte.
    always @(negedge clk) begin
        if (tx_load) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_load_unexpected: got %0h expected no load", tx_byte);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (tx_byte !== e) begin
                    errors++;
                    $display("FAIL tx_byte: got %0h expected %0h", tx_byte, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit drop);
        step();
        rx_valid = 1'b1;
        rx_byte  = b;
        if (drop) ssel_active = 1'b0;
        step();
        rx_valid = 1'b0;
        rx_byte  = 8'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1; ssel_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        step(); step();
        rst = 1'b0;
        m_reset();
    endtask

    // mode: 0 none, 1 write, 2 read, 3 error
    task automatic run_frame(input logic [7:0] bytes[$], input bit drop_last);
        int mode = 0;
        logic [3:0] a = 4'h0;
        bit last_drop;
        step();
        ssel_active = 1'b1;
        foreach (bytes[i]) begin
            logic [7:0] b;
            b = bytes[i];
            last_drop = drop_last && (i == bytes.size() - 1);
            if (i == 0) begin
                if (b[6:4] != 3'b000) begin
                    mode = 3;
                    m_err = 1'b1;
                end else begin
                    a = b[3:0];
                    mode = b[7] ? 1 : 2;
                    if (mode == 2 && !last_drop) exp_q.push_back(m_read(a));
                end
            end else if (mode == 1) begin
                m_write(a, b);
                a = a + 4'd1;
            end else if (mode == 2) begin
                a = a + 4'd1;
                if (!last_drop) exp_q.push_back(m_read(a));
            end
            send_byte(b, last_drop);
            repeat ($urandom_range(0, 2)) step();
        end
        if (!(drop_last && bytes.size() > 0)) begin
            step();
            ssel_active = 1'b0;
        end
        step(); step();
        if (mode == 1 || mode == 2) m_fcnt = m_fcnt + 8'd1;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_leds"}, 32'(leds), 32'(m_led));
        chk({tag, "_cmd_err"}, 32'(cmd_err), 32'(m_err));
        if (!m_blink) chk({tag, "_pmod"}, 32'(pmod), 32'(m_lvl));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        do_reset();
        chk("reset_leds", 32'(leds), 0);
        chk("reset_cmd_err", 32'(cmd_err), 0);
        chk("reset_pmod", 32'(pmod), 0);
        chk("reset_tx_byte", 32'(tx_byte), 0);
        chk("reset_tx_load", 32'(tx_load), 0);

        q = '{8'h80, 8'h05};             run_frame(q, 0); check_outputs("wr_led");
        q = '{8'h04};                    run_frame(q, 0);
        q = '{8'h0F, 8'h00, 8'h00};      run_frame(q, 0);
        q = '{8'h83, 8'h11, 8'h22};      run_frame(q, 0);
        q = '{8'h03, 8'h00, 8'h00};      run_frame(q, 0);
        q = '{8'h90, 8'h0F};             run_frame(q, 0); check_outputs("err_frame");
        q = '{8'h04};                    run_frame(q, 0); check_outputs("err_sticky");
        q = '{8'h81, 8'h02, 8'h07};      run_frame(q, 0); check_outputs("pmod_ctrl");
        q = '{8'h01, 8'h00};             run_frame(q, 0);
        q = '{8'h83, 8'h5C};             run_frame(q, 1); check_outputs("drop_write");
        q = '{8'h03};                    run_frame(q, 0);

        // Bytes while deselected must be ignored.
        send_byte(8'h80, 0);
        send_byte(8'h0F, 0);
        step();
        check_outputs("idle_rx");
        q = '{};                         run_frame(q, 0);
        q = '{8'h04};                    run_frame(q, 0);

        for (int n = 0; n < 150; n++) begin
            logic [7:0] cmd;
            int len;
            cmd = 8'($urandom);
            if ($urandom_range(0, 9) != 0) cmd[6:4] = 3'b000;
            if ($urandom_range(0, 3) != 0) cmd[3:0] = 4'($urandom_range(0, 5));
            len = $urandom_range(0, 4);
            q = '{cmd};
            for (int k = 0; k < len; k++) q.push_back(8'($urandom));
            if ($urandom_range(0, 15) == 0) q = '{};
            run_frame(q, ($urandom_range(0, 4) == 0));
            check_outputs("random");
        end
        chk("queue_drained", exp_q.size(), 0);

        // Reset in the middle of a write frame.
        do_reset();
        step();
        ssel_active = 1'b1;
        send_byte(8'h80, 0);
        send_byte(8'h0A, 0);
        m_write(4'h0, 8'h0A);
        check_outputs("pre_abort");
        rst = 1'b1; ssel_active = 1'b0;
        step(); step();
        rst = 1'b0;
        m_reset();
        send_byte(8'h0B, 0);
        step();
        check_outputs("post_abort");
        q = '{8'h00, 8'h00};             run_frame(q, 0);
        q = '{8'h04};                    run_frame(q, 0);

`ifdef SPI_REG_CTRL_BLINK_EN
        begin
            int n = 0;
            do_reset();
            step();
            ssel_active = 1'b1;
            send_byte(8'h81, 0);
            send_byte(8'h02, 0);
            while (pmod !== 1'b1 && n < 70000) begin
                step();
                n++;
            end
            chk("blink_period", n, 65536);
            ssel_active = 1'b0;
            step(); step();
            m_write(4'h1, 8'h02);
            m_fcnt = m_fcnt + 8'd1;
        end
`endif

        repeat (3) step();
        chk("queue_empty_end", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
